// File: rtl/scene_pkg.sv
// Shared definitions for the screen-phase sequencer: phase encoding and width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scene_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_SPLASH    = 2'd0,
    PH_PLAY      = 2'd1,
    PH_OVER_WAIT = 2'd2,
    PH_OVER_SHOW = 2'd3
  } phase_e;

endpackage

// File: rtl/layer_priority_mux.sv
// Picks the highest-index effective layer pixel; index 0 is lowest priority.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   eff_vld  [LAYERS]        per-layer effective flags (already masked/keyed)
//   pix_dat  [LAYERS*RGB_W]  packed layer pixels, layer k at [k*RGB_W +: RGB_W]
//   win_dat  [RGB_W]         winning pixel, 0 when nothing is effective
//   any_vld                  at least one layer is effective
module layer_priority_mux #(
  parameter int LAYERS = 3,
  parameter int RGB_W  = 12
) (
  input  logic [LAYERS-1:0]       eff_vld,
  input  logic [LAYERS*RGB_W-1:0] pix_dat,
  output logic [RGB_W-1:0]        win_dat,
  output logic                    any_vld
);

  // Ascending scan: a later (higher-index) hit overwrites earlier ones.
  always_comb begin
    win_dat = '0;
    for (int k = 0; k < LAYERS; k++) begin
      if (eff_vld[k]) begin
        win_dat = pix_dat[k*RGB_W +: RGB_W];
      end
    end
  end

  assign any_vld = |eff_vld;

endmodule

// File: rtl/scene_sequencer.sv
// Screen-phase FSM (splash/play/game-over), N-layer compositor and scroll generator.
// Latency: rgb and phase flags registered, 1 cycle from inputs.
// Backpressure: none; consumes inputs every cycle, outputs always valid.
//
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   video_on, f_tick       active-video flag, one-cycle frame pulse
//   start, game_over       splash skip pulse, game-over level
//   layer_on, layer_rgb    per-layer valid flags and packed pixels
//   rgb                    composited pixel
//   phase, game_begin, over_display   phase code and derived flags
//   scroll_x               horizontal scroll offset, wraps at SCROLL_MOD
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int                LAYERS       = 3,
  parameter int                RGB_W        = 12,
  parameter int unsigned       SPLASH_TICKS = 500_000_000,
  parameter int unsigned       OVER_TICKS   = 5_000,
  parameter logic [LAYERS-1:0] SPLASH_MASK  = LAYERS'(3'b110),
  parameter logic [LAYERS-1:0] PLAY_MASK    = LAYERS'(3'b111),
  parameter logic [LAYERS-1:0] OVER_MASK    = LAYERS'(3'b110),
  parameter bit                TRANSP_EN    = 1'b0,
  parameter logic [RGB_W-1:0]  TRANSP_KEY   = '0,
  parameter int                SCROLL_MOD   = 640,
  parameter int                SCROLL_DIV   = 1
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          video_on,
  input  logic                          f_tick,
  input  logic                          start,
  input  logic                          game_over,
  input  logic [LAYERS-1:0]             layer_on,
  input  logic [LAYERS*RGB_W-1:0]       layer_rgb,
  output logic [RGB_W-1:0]              rgb,
  output logic [PHASE_W-1:0]            phase,
  output logic                          game_begin,
  output logic                          over_display,
  output logic [$clog2(SCROLL_MOD)-1:0] scroll_x
);

  localparam int SX_W  = $clog2(SCROLL_MOD);
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  // Terminal timer values; the zero-tick cases are handled separately so
  // these never underflow.
  localparam logic [31:0] SPLASH_LAST = (SPLASH_TICKS == 0) ? 32'd0 : 32'(SPLASH_TICKS - 1);
  localparam logic [31:0] OVER_LAST   = (OVER_TICKS == 0)   ? 32'd0 : 32'(OVER_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [SX_W-1:0]  SX_LAST  = SX_W'(SCROLL_MOD - 1);

  phase_e            phase_q, phase_d;
  logic [31:0]       timer_q, timer_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SX_W-1:0]   scroll_q, scroll_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              game_begin_q, game_begin_d;
  logic              over_display_q, over_display_d;

  logic [LAYERS-1:0] mask;
  logic [LAYERS-1:0] eff_vld;
  logic [RGB_W-1:0]  win_dat;
  logic              any_vld;

  // Phase FSM: timer restarts from 0 on every transition.
  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    case (phase_q)
      PH_SPLASH: begin
        if ((SPLASH_TICKS == 0) || start || (timer_q == SPLASH_LAST)) begin
          phase_d = PH_PLAY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      PH_PLAY: begin
        if (game_over) begin
          phase_d = PH_OVER_WAIT;
          timer_d = '0;
        end
      end
      PH_OVER_WAIT: begin
        // game_over is not re-examined here: the event is latched.
        if ((OVER_TICKS == 0) || (timer_q == OVER_LAST)) begin
          phase_d = PH_OVER_SHOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        phase_d = phase_q;
      end
    endcase
  end

  // Flags follow the next phase so they update on the same edge as phase.
  always_comb begin
    game_begin_d   = (phase_d != PH_SPLASH);
    over_display_d = (phase_d == PH_OVER_SHOW);
  end

  // Scroll advances only while the registered phase is PLAY, so an f_tick on
  // the PLAY->OVER_WAIT edge still counts.
  always_comb begin
    div_d    = div_q;
    scroll_d = scroll_q;
    if ((phase_q == PH_PLAY) && f_tick) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        scroll_d = (scroll_q == SX_LAST) ? '0 : scroll_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Mask from the registered phase: on a transition edge the old mask applies.
  always_comb begin
    case (phase_q)
      PH_SPLASH: mask = SPLASH_MASK;
      PH_PLAY:   mask = PLAY_MASK;
      default:   mask = OVER_MASK;
    endcase
  end

  always_comb begin
    eff_vld = '0;
    for (int k = 0; k < LAYERS; k++) begin
      eff_vld[k] = layer_on[k] && mask[k] &&
                   !(TRANSP_EN && (layer_rgb[k*RGB_W +: RGB_W] == TRANSP_KEY));
    end
  end

  layer_priority_mux #(
    .LAYERS (LAYERS),
    .RGB_W  (RGB_W)
  ) u_mux (
    .eff_vld (eff_vld),
    .pix_dat (layer_rgb),
    .win_dat (win_dat),
    .any_vld (any_vld)
  );

  always_comb begin
    rgb_d = (video_on && any_vld) ? win_dat : '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      phase_q        <= PH_SPLASH;
      timer_q        <= '0;
      div_q          <= '0;
      scroll_q       <= '0;
      rgb_q          <= '0;
      game_begin_q   <= 1'b0;
      over_display_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      timer_q        <= timer_d;
      div_q          <= div_d;
      scroll_q       <= scroll_d;
      rgb_q          <= rgb_d;
      game_begin_q   <= game_begin_d;
      over_display_q <= over_display_d;
    end
  end

  assign rgb          = rgb_q;
  assign phase        = phase_q;
  assign game_begin   = game_begin_q;
  assign over_display = over_display_q;
  assign scroll_x     = scroll_q;

endmodule
